// File: rtl/dm_sram_responder.sv
// Data-memory responder: word-addressed SRAM with bit-masked writes, RD_LAT 1/2 read pipeline
// and a self-clearing INIT sweep after reset. Optional access statistics: DM_ACCESS_STATS_EN.
module dm_sram_responder #(
    parameter int          ADDR_W     = 14,
    parameter int          DEPTH      = 16384,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_data_in,
    input  logic              dm_web,
    input  logic [31:0]       dm_bweb,
    output logic [31:0]       dm_data_out,
    output logic              init_done
`ifdef DM_ACCESS_STATS_EN
    ,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       rd_cnt,
    output logic              oob_flag
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic              port_we;
    logic [31:0]       rd1_q, rd1_d;

    // Upper address bits alias onto the same words.
    assign idx = dm_addr[IDX_W-1:0];

    generate
        if (IDX_W < ADDR_W) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^dm_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    always_comb begin
        rd_word = mem[idx];
        merged  = (rd_word & dm_bweb) | (dm_data_in & ~dm_bweb);
        port_we = (state_q == ST_READY) && !dm_web;
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Array has no reset; writes are gated by rst so an edge coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                mem[init_cnt_q] <= INIT_VALUE;
            end else if (port_we) begin
                mem[idx] <= merged;
            end
        end
    end

    // Stage 1 is write-first: a write cycle returns the merged word.
    always_comb begin
        rd1_d = '0;
        if (state_q == ST_READY) begin
            rd1_d = port_we ? merged : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_q <= '0;
        end else begin
            rd1_q <= rd1_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [31:0] rd2_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd2_q <= '0;
                end else begin
                    rd2_q <= rd1_q;
                end
            end
            assign dm_data_out = rd2_q;
        end else begin : g_lat1
            assign dm_data_out = rd1_q;
        end
    endgenerate

    assign init_done = (state_q == ST_READY);

`ifdef DM_ACCESS_STATS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;
    logic        oob_q;
    logic        addr_oob;

    assign addr_oob = ({1'b0, dm_addr} >= (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            oob_q    <= 1'b0;
        end else if (state_q == ST_READY) begin
            if (!dm_web && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (dm_web && rd_cnt_q != 32'hFFFF_FFFF)  rd_cnt_q <= rd_cnt_q + 32'd1;
            if (addr_oob) oob_q <= 1'b1;
        end
    end

    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;
    assign oob_flag = oob_q;
`endif

endmodule

// File: tb/tb_dm_sram_responder.sv
// Directed bench: two instances (RD_LAT 1 and 2, DEPTH 16) share one stimulus port.
module tb_dm_sram_responder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_data_in;
    logic              dm_web;
    logic [31:0]       dm_bweb;
    logic [31:0]       out1, out2;
    logic              done1, done2;
`ifdef DM_ACCESS_STATS_EN
    logic [31:0]       wr1, rd1, wr2, rd2;
    logic              oob1, oob2;
`endif

    int total;
    int bad;

    dm_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1), .INIT_VALUE(32'h0)) u1 (
        .clk(clk), .rst(rst), .dm_addr(dm_addr), .dm_data_in(dm_data_in),
        .dm_web(dm_web), .dm_bweb(dm_bweb), .dm_data_out(out1), .init_done(done1)
`ifdef DM_ACCESS_STATS_EN
        , .wr_cnt(wr1), .rd_cnt(rd1), .oob_flag(oob1)
`endif
    );

    dm_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2), .INIT_VALUE(32'h0)) u2 (
        .clk(clk), .rst(rst), .dm_addr(dm_addr), .dm_data_in(dm_data_in),
        .dm_web(dm_web), .dm_bweb(dm_bweb), .dm_data_out(out2), .init_done(done2)
`ifdef DM_ACCESS_STATS_EN
        , .wr_cnt(wr2), .rd_cnt(rd2), .oob_flag(oob2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic web, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [31:0] m);
        dm_web = web; dm_addr = a; dm_data_in = d; dm_bweb = m;
    endtask

    // Releases reset and counts edges to init_done while driving junk writes to word 0.
    task automatic release_and_wait(input string tag);
        int n;
        n = 0;
        drive(1'b0, '0, 32'hFFFF_FFFF, 32'h0);
        rst = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 8) begin
                total++;
                if (out1 !== 32'h0 || out2 !== 32'h0) begin
                    bad++;
                    $display("FAIL %s_init_out: out1=%h out2=%h expected 0", tag, out1, out2);
                end
            end
            if (done1 && n == 0) n = k;
            if (done1) break;
        end
        total++;
        if (n != DEPTH || done2 !== 1'b1) begin
            bad++;
            $display("FAIL %s_init_len: cycles=%0d done2=%b expected %0d,1", tag, n, done2, DEPTH);
        end
        total++;
        if (out1 !== 32'h0 || out2 !== 32'h0) begin
            bad++;
            $display("FAIL %s_first_ready: out1=%h out2=%h expected 0", tag, out1, out2);
        end
        drive(1'b1, '0, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, '0, 32'h0, 32'hFFFF_FFFF);
        step();
        step();
        total++;
        if (out1 !== 32'h0 || out2 !== 32'h0 || done1 !== 1'b0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out1=%h out2=%h done=%b%b expected 0,0,00", out1, out2, done1, done2);
        end
        release_and_wait("boot");
    endtask

    task automatic test_init_contents();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, ADDR_W'(i), 32'h5A5A_5A5A, 32'h0);
            step();
            total++;
            if (out1 !== 32'h0) begin
                bad++;
                $display("FAIL init_word%0d: got %h expected 00000000", i, out1);
            end
        end
    endtask

    task automatic test_write_latency();
        drive(1'b0, 8'd3, 32'hDEAD_BEEF, 32'h0);
        step();
        total++;
        if (out1 !== 32'hDEAD_BEEF || out2 !== 32'h0) begin
            bad++;
            $display("FAIL wr3_lat: out1=%h out2=%h expected deadbeef,00000000", out1, out2);
        end
        drive(1'b1, 8'd3, 32'h0, 32'h0);
        step();
        total++;
        if (out1 !== 32'hDEAD_BEEF || out2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rd3_lat: out1=%h out2=%h expected deadbeef,deadbeef", out1, out2);
        end
    endtask

    task automatic test_bit_mask();
        drive(1'b0, 8'd5, 32'h1122_3344, 32'h0);
        step();
        drive(1'b0, 8'd5, 32'hAA00_0000, 32'h00FF_FFFF);
        step();
        total++;
        if (out1 !== 32'hAA22_3344) begin
            bad++;
            $display("FAIL mask_wrcycle: got %h expected aa223344", out1);
        end
        drive(1'b1, 8'd5, 32'hFFFF_FFFF, 32'h0);
        step();
        total++;
        if (out1 !== 32'hAA22_3344 || out2 !== 32'hAA22_3344) begin
            bad++;
            $display("FAIL mask_read: out1=%h out2=%h expected aa223344", out1, out2);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 8'd2, 32'h0000_0055, 32'h0);
        step();
        total++;
        if (out1 !== 32'h0000_0055) begin
            bad++;
            $display("FAIL b2b_write: got %h expected 00000055", out1);
        end
        drive(1'b1, 8'd2, 32'hFFFF_FFFF, 32'h0);
        step();
        total++;
        if (out1 !== 32'h0000_0055 || out2 !== 32'h0000_0055) begin
            bad++;
            $display("FAIL b2b_read: out1=%h out2=%h expected 00000055", out1, out2);
        end
        drive(1'b0, 8'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 8'd2, 32'h0, 32'h0);
        step();
        total++;
        if (out1 !== 32'h0000_0055) begin
            bad++;
            $display("FAIL noop_write: got %h expected 00000055", out1);
        end
    endtask

    task automatic test_alias();
        drive(1'b0, 8'd20, 32'h0000_CAFE, 32'h0);
        step();
        drive(1'b1, 8'd4, 32'h0, 32'h0);
        step();
        total++;
        if (out1 !== 32'h0000_CAFE) begin
            bad++;
            $display("FAIL alias_20_4: got %h expected 0000cafe", out1);
        end
    endtask

    task automatic test_reset_mid_ready();
        drive(1'b1, 8'd3, 32'h0, 32'h0);
        step();
        step();
        #2;
        rst = 1'b0;
        drive(1'b0, 8'd3, 32'h1234_5678, 32'h0);
        #1;
        total++;
        if (out1 !== 32'h0 || out2 !== 32'h0 || done1 !== 1'b0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: out1=%h out2=%h done=%b%b expected 0,0,00", out1, out2, done1, done2);
        end
        step();
        release_and_wait("reinit");
`ifdef DM_ACCESS_STATS_EN
        drive(1'b0, 8'd6, 32'h1, 32'h0); step();
        drive(1'b0, 8'd7, 32'h2, 32'h0); step();
        drive(1'b0, 8'd8, 32'h3, 32'h0); step();
        drive(1'b1, 8'd6, 32'h0, 32'h0); step();
        drive(1'b1, 8'd7, 32'h0, 32'h0); step();
        drive(1'b1, 8'd20, 32'h0, 32'h0); step();
        total++;
        if (wr1 !== 32'd3 || rd1 !== 32'd3 || oob1 !== 1'b1) begin
            bad++;
            $display("FAIL stats: wr=%0d rd=%0d oob=%b expected 3,3,1", wr1, rd1, oob1);
        end
`endif
        drive(1'b1, 8'd3, 32'h0, 32'h0);
        step();
        total++;
        if (out1 !== 32'h0) begin
            bad++;
            $display("FAIL reinit_word3: got %h expected 00000000", out1);
        end
        drive(1'b1, 8'd0, 32'h0, 32'h0);
        step();
        total++;
        if (out1 !== 32'h0) begin
            bad++;
            $display("FAIL reinit_word0: got %h expected 00000000", out1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_init_contents();
        test_write_latency();
        test_bit_mask();
        test_back_to_back();
        test_alias();
        test_reset_mid_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
